phase_sequencer: RTL and testbench

//   Parametrised successor to the fixed 5-phase core statemachine. Sequences a one-hot

---
 rtl/phase_seq_if.sv | 28 ++
 rtl/phase_sequencer.sv | 85 ++++++++
 tb/tb_phase_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/phase_seq_if.sv
// Handshake bundle for phase_sequencer: control inputs from the control unit,
// phase/retire status back out to the per-stage enables.
interface phase_seq_if #(
    parameter int NUM_PHASES = 5,
    parameter int CNT_W      = 32
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0] stall;
    logic [NUM_PHASES-1:0] skip;
    logic                  flush;
    logic                  halt_req;
    logic [NUM_PHASES-1:0] current;
    logic [IDX_W-1:0]      phase_idx;
    logic                  retire;
    logic [CNT_W-1:0]      instret;
    logic                  halted;

    modport master (
        output stall, skip, flush, halt_req,
        input  current, phase_idx, retire, instret, halted
    );

    modport slave (
        input  stall, skip, flush, halt_req,
        output current, phase_idx, retire, instret, halted
    );
endinterface

// File: rtl/phase_sequencer.sv
// One-hot instruction phase sequencer with per-phase skip/stall, flush,
// halt/resume at instruction boundaries and a retired-instruction counter.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int CNT_W      = 32
) (
    input logic       clk,
    input logic       rst_n,
    phase_seq_if.slave bus
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0] cur_q, cur_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  halted_q, halted_d;
    logic                  retire_q, retire_d;
    logic [CNT_W-1:0]      instret_q, instret_d;

    logic                  found;
    logic [IDX_W-1:0]      nxt;

    // skip[0] is meaningless: phase 0 is always entered
    wire unused_skip0 = bus.skip[0];

    // Lowest later phase that is not skipped; scanning downward lets the
    // lowest match win.
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int j = NUM_PHASES - 1; j >= 1; j--) begin
            if (j > int'(idx_q) && !bus.skip[j]) begin
                found = 1'b1;
                nxt   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        idx_d     = idx_q;
        halted_d  = halted_q;
        retire_d  = 1'b0;
        instret_d = instret_q;
        if (halted_q) begin
            if (!bus.halt_req) begin
                halted_d = 1'b0;
                idx_d    = '0;
            end
        end else if (bus.flush) begin
            idx_d    = '0;
            halted_d = bus.halt_req;
        end else if (bus.stall[idx_q]) begin
            idx_d = idx_q;
        end else if (found) begin
            idx_d = nxt;
        end else begin
            retire_d  = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            idx_d     = '0;
            halted_d  = bus.halt_req;
        end
        cur_d = halted_d ? '0 : (NUM_PHASES'(1) << idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= NUM_PHASES'(1);
            idx_q     <= '0;
            halted_q  <= 1'b0;
            retire_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            halted_q  <= halted_d;
            retire_q  <= retire_d;
            instret_q <= instret_d;
        end
    end

    assign bus.current   = cur_q;
    assign bus.phase_idx = idx_q;
    assign bus.retire    = retire_q;
    assign bus.instret   = instret_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed vector bench for phase_sequencer (N=5, 4-bit instret).
module tb_phase_sequencer;
    localparam int N = 5;
    localparam int W = 4;

    typedef struct {
        logic [N-1:0] stall;
        logic [N-1:0] skip;
        logic         flush;
        logic         halt;
        int           cur;
        int           ret;
        int           inst;
        int           hlt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    phase_seq_if #(.NUM_PHASES(N), .CNT_W(W)) bus ();

    phase_sequencer #(.NUM_PHASES(N), .CNT_W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input int cur);
        int r = 0;
        for (int i = 0; i < N; i++)
            if (cur == (1 << i)) r = i;
        return r;
    endfunction

    task automatic add(input logic [N-1:0] st, input logic [N-1:0] sk,
                       input logic fl, input logic hr, input int cur,
                       input int ret, input int inst, input int hlt);
        vec_t v;
        v.stall = st; v.skip = sk; v.flush = fl; v.halt = hr;
        v.cur = cur; v.ret = ret; v.inst = inst; v.hlt = hlt;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string tag, input int cur, input int ret,
                              input int inst, input int hlt);
        chk({tag, " current"}, int'(bus.current), cur);
        chk({tag, " phase_idx"}, int'(bus.phase_idx), idx_of(cur));
        chk({tag, " retire"}, int'(bus.retire), ret);
        chk({tag, " instret"}, int'(bus.instret), inst);
        chk({tag, " halted"}, int'(bus.halted), hlt);
    endtask

    initial begin
        // plain run: 15 cycles, 3 retires
        for (int c = 1; c <= 15; c++)
            add('0, '0, 0, 0, 1 << (c % 5), (c % 5 == 0) ? 1 : 0, c / 5, 0);
        // stall on non-current phase ignored; stall[2] holds phase 2
        add(5'b01000, '0, 0, 0, 2, 0, 3, 0);
        add('0, '0, 0, 0, 4, 0, 3, 0);
        add(5'b00100, '0, 0, 0, 4, 0, 3, 0);
        add(5'b00100, '0, 0, 0, 4, 0, 3, 0);
        add(5'b00100, '0, 0, 0, 4, 0, 3, 0);
        add('0, '0, 0, 0, 8, 0, 3, 0);
        add('0, '0, 0, 0, 16, 0, 3, 0);
        add('0, '0, 0, 0, 1, 1, 4, 0);
        // skip phase 3
        add('0, 5'b01000, 0, 0, 2, 0, 4, 0);
        add('0, 5'b01000, 0, 0, 4, 0, 4, 0);
        add('0, 5'b01000, 0, 0, 16, 0, 4, 0);
        add('0, 5'b01000, 0, 0, 1, 1, 5, 0);
        // 1-cycle instructions
        add('0, 5'b11110, 0, 0, 1, 1, 6, 0);
        add('0, 5'b11110, 0, 0, 1, 1, 7, 0);
        add('0, 5'b11110, 0, 0, 1, 1, 8, 0);
        // flush beats stall at phase 3
        add('0, '0, 0, 0, 2, 0, 8, 0);
        add('0, '0, 0, 0, 4, 0, 8, 0);
        add('0, '0, 0, 0, 8, 0, 8, 0);
        add(5'b01000, '0, 1, 0, 1, 0, 8, 0);
        add('0, '0, 0, 0, 2, 0, 8, 0);
        // halt requested mid-instruction takes effect at the boundary
        add('0, '0, 0, 1, 4, 0, 8, 0);
        add('0, '0, 0, 1, 8, 0, 8, 0);
        add('0, '0, 0, 1, 16, 0, 8, 0);
        add('0, '0, 0, 1, 0, 1, 9, 1);
        add('1, '1, 1, 1, 0, 0, 9, 1);
        add('0, '0, 0, 0, 1, 0, 9, 0);
        // flush with halt_req halts without retire
        add('0, '0, 1, 1, 0, 0, 9, 1);
        add('0, '0, 0, 0, 1, 0, 9, 0);
        // flush on the completing cycle wins
        add('0, '0, 0, 0, 2, 0, 9, 0);
        add('0, '0, 0, 0, 4, 0, 9, 0);
        add('0, '0, 0, 0, 8, 0, 9, 0);
        add('0, '0, 0, 0, 16, 0, 9, 0);
        add('0, '0, 1, 0, 1, 0, 9, 0);
        // instret wrap 15 -> 0
        for (int k = 10; k <= 17; k++)
            add('0, 5'b11110, 0, 0, 1, 1, k % 16, 0);
        add('0, '0, 0, 0, 2, 0, 1, 0);
        add('0, '0, 0, 0, 4, 0, 1, 0);
        add('0, '0, 0, 0, 8, 0, 1, 0);

        bus.stall = '0;
        bus.skip = '0;
        bus.flush = 1'b0;
        bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.stall = vecs[i].stall;
            bus.skip = vecs[i].skip;
            bus.flush = vecs[i].flush;
            bus.halt_req = vecs[i].halt;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].cur, vecs[i].ret,
                       vecs[i].inst, vecs[i].hlt);
        end

        // asynchronous reset in phase 3, no clock edge needed
        bus.stall = '0;
        bus.skip = '0;
        #1 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("rst_hold", 1, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_rst", 2, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
